sp_sync_ctrl: RTL and testbench

Link-synchronisation controller for the PHY serial-to-parallel receive path, running in the `clk_32f` domain. It watches the MSB-first serial stream on `data_in` and finds byte alignment on the comma word 0xBC. After `BC_LOCK` consecutive aligned commas it declares the link active. From then on it emits one parallel byte per 8 bits, with a valid flag that separates payload from idle commas, and a word strobe for the downstream byte-rate logic.

---
 rtl/phy_pkg.sv | 19 +
 rtl/comma_detect.sv | 31 +++
 rtl/sp_sync_ctrl.sv | 102 ++++++++++
 tb/tb_sp_sync_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phy_pkg : shared constants and state encoding for the PHY receive path
// Rev 1.0
// ---------------------------------------------------------------------------
package phy_pkg;

   localparam logic [7:0] COMMA_BC = 8'hBC;
   localparam logic [7:0] K_7C     = 8'h7C;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ALIGN   = 2'd1,
      ACTIVE  = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/comma_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// comma_detect : serial shift register with 0xBC comparator on the new byte
// Rev 1.0
// ---------------------------------------------------------------------------
module comma_detect
   import phy_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       data_in,
   output logic [7:0] nsr,
   output logic       is_comma
);

   // Only the low 7 history bits ever reach nsr, so the oldest bit is not stored.
   logic [6:0] sr;

   assign nsr      = {sr, data_in};
   assign is_comma = (nsr == COMMA_BC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= 7'd0;
      end else begin
         sr <= nsr[6:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/sp_sync_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sp_sync_ctrl : comma-based byte alignment and link lock for serial RX
// Rev 1.0
// ---------------------------------------------------------------------------
module sp_sync_ctrl
   import phy_pkg::*;
#(
   parameter int BC_LOCK = 4
) (
   input  logic       clk_32f,
   input  logic       default_values,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       word_strobe,
   output logic       active,
   output logic [1:0] state_o
);

   localparam logic [3:0] LOCK = 4'(BC_LOCK);

   logic [7:0] nsr;
   logic       is_comma;
   state_t     state;
   logic [2:0] bit_cnt;
   logic [3:0] bc_cnt;
   logic       boundary;
   logic       last_comma;

   comma_detect u_comma_detect (
      .clk      (clk_32f),
      .rst      (default_values),
      .data_in  (data_in),
      .nsr      (nsr),
      .is_comma (is_comma)
   );

   assign boundary   = (bit_cnt == 3'd7);
   assign last_comma = ((bc_cnt + 4'd1) == LOCK);
   assign state_o    = state;

   always_ff @(posedge clk_32f or posedge default_values) begin
      if (default_values) begin
         state       <= SEARCH;
         bit_cnt     <= 3'd0;
         bc_cnt      <= 4'd0;
         data_out    <= 8'h00;
         valid_out   <= 1'b0;
         word_strobe <= 1'b0;
         active      <= 1'b0;
      end else begin
         word_strobe <= 1'b0;
         case (state)
            SEARCH: begin
               if (is_comma) begin
                  bit_cnt <= 3'd0;
                  bc_cnt  <= 4'd1;
                  if (LOCK == 4'd1) begin
                     state  <= ACTIVE;
                     active <= 1'b1;
                  end else begin
                     state <= ALIGN;
                  end
               end
            end
            ALIGN: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (boundary) begin
                  if (is_comma) begin
                     bc_cnt <= bc_cnt + 4'd1;
                     if (last_comma) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     // Misaligned byte: restart the hunt on the next bit.
                     state  <= SEARCH;
                     bc_cnt <= 4'd0;
                  end
               end
            end
            ACTIVE: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (boundary) begin
                  data_out    <= nsr;
                  word_strobe <= 1'b1;
                  valid_out   <= ~is_comma;
               end
            end
            default: begin
               state   <= SEARCH;
               active  <= 1'b0;
               bit_cnt <= 3'd0;
               bc_cnt  <= 4'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sp_sync_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sp_sync_ctrl : scoreboard bench, BC_LOCK=4 and BC_LOCK=1 on one stream
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sp_sync_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic din;

   logic [7:0] d4, d1;
   logic       v4, v1, s4, s1, a4, a1;
   logic [1:0] st4, st1;

   always #5 clk = ~clk;

   sp_sync_ctrl #(.BC_LOCK(4)) dut4 (
      .clk_32f(clk), .default_values(rst), .data_in(din),
      .data_out(d4), .valid_out(v4), .word_strobe(s4), .active(a4), .state_o(st4)
   );

   sp_sync_ctrl #(.BC_LOCK(1)) dut1 (
      .clk_32f(clk), .default_values(rst), .data_in(din),
      .data_out(d1), .valid_out(v1), .word_strobe(s1), .active(a1), .state_o(st1)
   );

   typedef struct {
      logic [7:0] d;
      logic       v;
      int         idx;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n        = 0;   // count of sampled bits since time zero

   // Reference: per lock setting, mode 0 = hunting, 1 = counting commas, 2 = locked;
   // nxt is the bit index at which the next aligned byte completes.
   int lockv[2] = '{4, 1};
   int mode[2];
   int cnt[2];
   int nxt[2];
   int win;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at bit %0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   task automatic model_reset();
      win = 0;
      for (int k = 0; k < 2; k++) begin
         mode[k] = 0;
         cnt[k]  = 0;
         nxt[k]  = 0;
      end
   endtask

   task automatic model_step(input logic b);
      exp_t e;
      win = ((win << 1) | int'(b)) & 255;
      for (int k = 0; k < 2; k++) begin
         if (mode[k] == 0) begin
            if (win == 188) begin
               cnt[k]  = 1;
               nxt[k]  = n + 8;
               mode[k] = (cnt[k] >= lockv[k]) ? 2 : 1;
            end
         end else if (mode[k] == 1) begin
            if (n == nxt[k]) begin
               if (win == 188) begin
                  cnt[k] = cnt[k] + 1;
                  nxt[k] = nxt[k] + 8;
                  if (cnt[k] == lockv[k]) mode[k] = 2;
               end else begin
                  mode[k] = 0;
                  cnt[k]  = 0;
               end
            end
         end else if (n == nxt[k]) begin
            e.d   = win[7:0];
            e.v   = (win != 188);
            e.idx = n;
            if (k == 0) q4.push_back(e);
            else        q1.push_back(e);
            nxt[k] = nxt[k] + 8;
         end
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      din = b;
      @(posedge clk);
      n++;
      model_step(b);
      #1;
      chk("active_l4", {31'd0, a4}, (mode[0] == 2) ? 1 : 0);
      chk("state_l4",  {30'd0, st4}, mode[0]);
      chk("active_l1", {31'd0, a1}, (mode[1] == 2) ? 1 : 0);
      chk("state_l1",  {30'd0, st1}, mode[1]);
   endtask

   task automatic send_byte(input logic [7:0] b8);
      for (int i = 7; i >= 0; i--) send_bit(b8[i]);
   endtask

   task automatic check_cleared();
      chk("rst_data_l4", {24'd0, d4}, 0);
      chk("rst_valid_l4", {31'd0, v4}, 0);
      chk("rst_strobe_l4", {31'd0, s4}, 0);
      chk("rst_active_l4", {31'd0, a4}, 0);
      chk("rst_state_l4", {30'd0, st4}, 0);
      chk("rst_data_l1", {24'd0, d1}, 0);
      chk("rst_valid_l1", {31'd0, v1}, 0);
      chk("rst_active_l1", {31'd0, a1}, 0);
      chk("rst_state_l1", {30'd0, st1}, 0);
   endtask

   // Reset lands between clock edges, after the monitor has consumed this cycle.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_cleared();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic monitor(input int k, input logic strobe, input logic [7:0] d, input logic v);
      exp_t e;
      int   sz;
      sz = (k == 0) ? q4.size() : q1.size();
      if (strobe) begin
         if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_l%0d at bit %0d: got unexpected strobe data %0h required none",
                     lockv[k], n, d);
         end else begin
            e = (k == 0) ? q4.pop_front() : q1.pop_front();
            chk($sformatf("data_l%0d", lockv[k]), {24'd0, d}, {24'd0, e.d});
            chk($sformatf("valid_l%0d", lockv[k]), {31'd0, v}, {31'd0, e.v});
            chk($sformatf("timing_l%0d", lockv[k]), n, e.idx);
         end
      end else if (sz != 0) begin
         e = (k == 0) ? q4[0] : q1[0];
         if (e.idx <= n) begin
            e = (k == 0) ? q4.pop_front() : q1.pop_front();
            chk($sformatf("strobe_l%0d", lockv[k]), 0, 1);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         monitor(0, s4, d4, v4);
         monitor(1, s1, d1, v1);
      end
   end

   initial begin
      rst = 1'b1;
      din = 1'b0;
      model_reset();
      @(negedge clk);
      #1 check_cleared();
      rst = 1'b0;

      // Lock, payload, idle commas, payload.
      repeat (4) send_byte(8'hBC);
      repeat (3) send_byte(8'h7C);
      repeat (4) send_byte(8'hBC);
      repeat (3) send_byte(8'h7C);

      // Lock attempt broken by a non-comma, then a clean lock.
      do_reset();
      repeat (3) send_byte(8'hBC);
      send_byte(8'h7C);
      repeat (4) send_byte(8'hBC);
      send_byte(8'h7C);

      // Three-bit offset before the commas.
      do_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      repeat (4) send_byte(8'hBC);
      send_byte(8'h7C);

      // Reset mid-byte while active, then re-lock.
      do_reset();
      repeat (4) send_byte(8'hBC);
      send_byte(8'h7C);
      for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
      do_reset();
      repeat (4) send_byte(8'hBC);
      send_byte(8'hA5);

      // Randomised bursts: slip bits, comma runs, payload with occasional idles.
      for (int r = 0; r < 30; r++) begin
         if ((r % 8) == 7) do_reset();
         for (int g = $urandom_range(0, 7); g > 0; g--) send_bit(1'($urandom_range(0, 1)));
         for (int c = $urandom_range(0, 5); c > 0; c--) send_byte(8'hBC);
         for (int p = $urandom_range(1, 6); p > 0; p--) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'hBC);
            else                           send_byte(8'($urandom_range(0, 255)));
         end
      end

      @(negedge clk);
      #1;
      chk("drained_l4", q4.size(), 0);
      chk("drained_l1", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
